argmax_stream16: RTL

//  Streaming max/argmax stage that consumes the 16-bit greater-than result of COMP16 (wx = x_a > x_b, unsigned).

---
 rtl/argmax_stream16_if.sv | 28 ++
 rtl/argmax_stream16.sv | 124 ++++++++++++
 2 files changed

// File: rtl/argmax_stream16_if.sv
// Stream bundle for argmax_stream16.
//   Input stream : in_valid, in_ready, in_data[15:0], in_last
//   Output stream: out_valid, out_ready, out_max[15:0], out_idx[IDX_W-1:0], out_ovf
// The slave modport is the argmax stage; the master modport is its environment,
// which drives the input stream and accepts results.
interface argmax_stream16_if #(
  parameter int IDX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_max;
  logic [IDX_W-1:0] out_idx;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_idx, out_ovf
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_idx, out_ovf
  );
endinterface

// File: rtl/argmax_stream16.sv
// Streaming max/argmax stage.
// Consumes a frame of unsigned 16-bit words and reports the frame maximum, the
// 0-based position of its first occurrence, and an overflow flag when the frame
// is longer than 2**IDX_W elements.
// Ports:
//   clk  - single clock, all state on rising edge
//   rst  - asynchronous, active-high reset
//   bus  - argmax_stream16_if.slave (input stream in, result stream out)
module argmax_stream16 #(
  parameter int IDX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  argmax_stream16_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // cnt == CNT_LIMIT means the beat being accepted has no representable index.
  localparam logic [IDX_W:0] CNT_LIMIT = {1'b1, {IDX_W{1'b0}}};

  state_t           state_q;
  logic [15:0]      max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q;

  logic accept;
  logic gt;
  logic at_limit;

  // Ready depends on state only, so upstream may wait on it without a loop.
  assign bus.in_ready = (state_q != S_DONE);
  assign accept       = bus.in_valid & bus.in_ready;

  // COMP16: strict unsigned greater-than, so ties keep the earlier position.
  assign gt       = (bus.in_data > max_q);
  assign at_limit = (cnt_q == CNT_LIMIT);

  // Datapath next-state for an accepted beat; committed only when accept is high.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    max_d = max_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (state_q == S_IDLE) begin
      // First beat of a frame seeds the running max unconditionally.
      max_d = bus.in_data;
      idx_d = '0;
      cnt_d = (IDX_W + 1)'(1);
      ovf_d = 1'b0;
    end else begin
      if (gt) begin
        max_d = bus.in_data;
      end
      // Once past the indexable range the index freezes at its last legal value.
      if (gt && !ovf_q && !at_limit) begin
        idx_d = cnt_q[IDX_W-1:0];
      end
      // Saturate the counter at the limit; ovf is sticky for the rest of the frame.
      if (at_limit) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + (IDX_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      max_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (accept) begin
        max_q <= max_d;
        idx_q <= idx_d;
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
      case (state_q)
        S_IDLE, S_ACC: begin
          if (accept) begin
            if (bus.in_last) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_ACC;
            end
          end
        end
        S_DONE: begin
          // out_valid is high throughout DONE, so out_ready alone completes the handshake.
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_max   = max_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_ovf   = ovf_q;

endmodule
